// File: rtl/imm_gen_pkg.sv
// Shared types for the ID-stage immediate generator.
// Format codes and base-ISA opcodes.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6
  } fmt_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

endpackage

// File: rtl/imm_gen_pipe_imm_decode.sv
// Combinational immediate decode: instr -> imm, fmt, illegal.
// Every format is built as a 32-bit signed value, then widened.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter bit SHIFT_BRANCH = 1'b1,
  parameter bit RV64_OPS     = 1'b1
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  localparam bit RV64_EN = RV64_OPS && (XLEN == 64);

  logic [6:0]  opc;
  logic        s;
  logic [11:0] b_field;
  logic [19:0] j_field;
  logic [31:0] i_val, s_val, b_val, u_val, j_val;
  logic [31:0] v;
  logic        is_i, is_s, is_b, is_u, is_j, is_r;

  assign opc     = instr[6:0];
  assign s       = instr[31];
  assign b_field = {instr[31], instr[7], instr[30:25], instr[11:8]};
  assign j_field = {instr[31], instr[19:12], instr[20], instr[30:21]};

  assign i_val = {{20{s}}, instr[31:20]};
  assign s_val = {{20{s}}, instr[31:25], instr[11:7]};
  assign u_val = {instr[31:12], 12'b0};
  assign b_val = SHIFT_BRANCH ? {{19{s}}, b_field, 1'b0}
                              : {{20{s}}, b_field};
  assign j_val = SHIFT_BRANCH ? {{11{s}}, j_field, 1'b0}
                              : {{12{s}}, j_field};

  assign is_i = (opc == OPC_LOAD) || (opc == OPC_OP_IMM) ||
                (opc == OPC_JALR) ||
                (RV64_EN && (opc == OPC_OP_IMM_32));
  assign is_s = (opc == OPC_STORE);
  assign is_b = (opc == OPC_BRANCH);
  assign is_u = (opc == OPC_LUI) || (opc == OPC_AUIPC);
  assign is_j = (opc == OPC_JAL);
  assign is_r = (opc == OPC_OP) || (opc == OPC_OP_32);

  always_comb begin
    v       = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    unique case (1'b1)
      is_i: begin v = i_val; fmt = FMT_I; end
      is_s: begin v = s_val; fmt = FMT_S; end
      is_b: begin v = b_val; fmt = FMT_B; end
      is_u: begin v = u_val; fmt = FMT_U; end
      is_j: begin v = j_val; fmt = FMT_J; end
      is_r: fmt = FMT_R;
      default: illegal = 1'b1;
    endcase
  end

  assign imm = XLEN'($signed(v));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer.
// in_ready depends only on held state, never on out_ready.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter bit SHIFT_BRANCH = 1'b1,
  parameter bit RV64_OPS     = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [31:0]     out_instr
);

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_ill;

  logic            skid_valid;
  logic [XLEN-1:0] skid_imm;
  fmt_e            skid_fmt;
  logic            skid_ill;
  logic [31:0]     skid_instr;
  fmt_e            out_fmt_q;

  logic accept, present, load_out;

  imm_decode #(
    .XLEN        (XLEN),
    .SHIFT_BRANCH(SHIFT_BRANCH),
    .RV64_OPS    (RV64_OPS)
  ) u_dec (
    .instr  (in_instr),
    .imm    (dec_imm),
    .fmt    (dec_fmt),
    .illegal(dec_ill)
  );

  assign in_ready = !reset && !skid_valid;
  assign accept   = in_valid && in_ready;
  assign present  = out_valid && out_ready;
  assign load_out = present || !out_valid;
  assign out_fmt  = out_fmt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_imm     <= '0;
      out_fmt_q   <= FMT_NONE;
      out_illegal <= 1'b0;
      out_instr   <= '0;
      skid_valid  <= 1'b0;
      skid_imm    <= '0;
      skid_fmt    <= FMT_NONE;
      skid_ill    <= 1'b0;
      skid_instr  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load_out) begin
      // skid is older than anything offered now, so it drains first
      if (skid_valid) begin
        out_valid   <= 1'b1;
        out_imm     <= skid_imm;
        out_fmt_q   <= skid_fmt;
        out_illegal <= skid_ill;
        out_instr   <= skid_instr;
        skid_valid  <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        out_imm     <= dec_imm;
        out_fmt_q   <= dec_fmt;
        out_illegal <= dec_ill;
        out_instr   <= in_instr;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_imm   <= dec_imm;
      skid_fmt   <= dec_fmt;
      skid_ill   <= dec_ill;
      skid_instr <= in_instr;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe (64-bit shifted and
// 32-bit unshifted instances share the same stimulus).
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_illegal;
  logic [31:0] out_instr;

  logic        in_ready32;
  logic        out_valid32;
  logic [31:0] out_imm32;
  logic [2:0]  out_fmt32;
  logic        out_illegal32;
  logic [31:0] out_instr32;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] I_LD   = 32'hFF813083;
  localparam logic [31:0] I_SD   = 32'h00553823;
  localparam logic [31:0] I_BEQ  = 32'hFE000EE3;
  localparam logic [31:0] I_LUI1 = 32'h12345037;
  localparam logic [31:0] I_LUI2 = 32'h80000037;
  localparam logic [31:0] I_JAL  = 32'hFFDFF06F;
  localparam logic [31:0] I_ADDW = 32'hFFF0009B;
  localparam logic [31:0] I_ADD  = 32'h00000033;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  imm_gen_pipe #(
    .XLEN(64), .SHIFT_BRANCH(1'b1), .RV64_OPS(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt),
    .out_illegal(out_illegal), .out_instr(out_instr)
  );

  imm_gen_pipe #(
    .XLEN(32), .SHIFT_BRANCH(1'b0), .RV64_OPS(1'b1)
  ) dut32 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .flush(flush),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_fmt(out_fmt32),
    .out_illegal(out_illegal32), .out_instr(out_instr32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change on negedge; outputs are read on negedge too.
  task automatic apply(input logic [31:0] ins);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = ins;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_instr = '0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || out_imm !== 64'd0 ||
        out_fmt !== FMT_NONE || out_illegal !== 1'b0 ||
        out_instr !== 32'd0) begin
      errors++;
      $display("FAIL rst_outs got v=%b imm=%h f=%0d il=%b ins=%h exp zeros",
               out_valid, out_imm, out_fmt, out_illegal, out_instr);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_release got rdy=%b v=%b exp rdy=1 v=0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_itype;
    apply(I_LD);
    checks++;
    if (out_valid !== 1'b1 || out_imm !== 64'hFFFFFFFFFFFFFFF8 ||
        out_fmt !== FMT_I || out_illegal !== 1'b0 ||
        out_instr !== I_LD) begin
      errors++;
      $display("FAIL ld got v=%b imm=%h f=%0d il=%b exp 1 fff8 2 0",
               out_valid, out_imm, out_fmt, out_illegal);
    end
    apply(I_ADDW);
    checks++;
    if (out_imm !== 64'hFFFFFFFFFFFFFFFF || out_fmt !== FMT_I ||
        out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL addiw got imm=%h f=%0d il=%b exp -1 2 0",
               out_imm, out_fmt, out_illegal);
    end
    checks++;
    if (out_illegal32 !== 1'b1 || out_fmt32 !== FMT_NONE ||
        out_imm32 !== 32'd0) begin
      errors++;
      $display("FAIL addiw32 got il=%b f=%0d imm=%h exp 1 0 0",
               out_illegal32, out_fmt32, out_imm32);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL drain got v=%b exp=0", out_valid);
    end
  endtask

  task automatic test_store_branch;
    apply(I_SD);
    checks++;
    if (out_imm !== 64'h10 || out_fmt !== FMT_S) begin
      errors++;
      $display("FAIL sd got imm=%h f=%0d exp 10 3", out_imm, out_fmt);
    end
    apply(I_BEQ);
    checks++;
    if (out_imm !== 64'hFFFFFFFFFFFFFFFC || out_fmt !== FMT_B) begin
      errors++;
      $display("FAIL beq got imm=%h f=%0d exp fffc 4", out_imm, out_fmt);
    end
    checks++;
    if (out_imm32 !== 32'hFFFFFFFE || out_fmt32 !== FMT_B) begin
      errors++;
      $display("FAIL beq32 got imm=%h exp fffffffe", out_imm32);
    end
    apply(I_JAL);
    checks++;
    if (out_imm !== 64'hFFFFFFFFFFFFFFFC || out_fmt !== FMT_J) begin
      errors++;
      $display("FAIL jal got imm=%h f=%0d exp fffc 6", out_imm, out_fmt);
    end
    checks++;
    if (out_imm32 !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL jal32 got imm=%h exp fffffffe", out_imm32);
    end
  endtask

  task automatic test_upper_illegal;
    apply(I_LUI1);
    checks++;
    if (out_imm !== 64'h0000000012345000 || out_fmt !== FMT_U) begin
      errors++;
      $display("FAIL lui1 got imm=%h f=%0d exp 12345000 5",
               out_imm, out_fmt);
    end
    apply(I_LUI2);
    checks++;
    if (out_imm !== 64'hFFFFFFFF80000000) begin
      errors++;
      $display("FAIL lui2 got imm=%h exp ffffffff80000000", out_imm);
    end
    checks++;
    if (out_imm32 !== 32'h80000000) begin
      errors++;
      $display("FAIL lui2_32 got imm=%h exp 80000000", out_imm32);
    end
    apply(I_ADD);
    checks++;
    if (out_fmt !== FMT_R || out_imm !== 64'd0 || out_illegal !== 1'b0) begin
      errors++;
      $display("FAIL rtype got f=%0d imm=%h il=%b exp 1 0 0",
               out_fmt, out_imm, out_illegal);
    end
    apply(I_BAD);
    checks++;
    if (out_fmt !== FMT_NONE || out_imm !== 64'd0 ||
        out_illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal got f=%0d imm=%h il=%b exp 0 0 1",
               out_fmt, out_imm, out_illegal);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_instr = I_LD;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_instr !== I_LD || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_a0 got v=%b ins=%h rdy=%b exp 1 %h 1",
               out_valid, out_instr, in_ready, I_LD);
    end
    in_instr = I_SD;
    @(negedge clk);
    checks++;
    if (out_instr !== I_LD || out_imm !== 64'hFFFFFFFFFFFFFFF8 ||
        in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_a1 got ins=%h imm=%h rdy=%b exp A held rdy=0",
               out_instr, out_imm, in_ready);
    end
    in_instr = I_LUI1;
    @(negedge clk);
    checks++;
    if (out_instr !== I_LD || out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_a2 got ins=%h v=%b rdy=%b exp A held rdy=0",
               out_instr, out_valid, in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_instr !== I_SD ||
        out_imm !== 64'h10 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_b got v=%b ins=%h imm=%h rdy=%b exp B rdy=1",
               out_valid, out_instr, out_imm, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_instr !== I_LUI1 ||
        out_imm !== 64'h12345000) begin
      errors++;
      $display("FAIL bp_c got v=%b ins=%h imm=%h exp C",
               out_valid, out_instr, out_imm);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_dup got v=%b exp=0", out_valid);
    end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_instr = I_LD;
    @(negedge clk);
    in_instr = I_SD;
    @(negedge clk);
    in_instr = I_BEQ;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush got v=%b rdy=%b exp v=0 rdy=1",
               out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_leak%0d got v=%b ins=%h exp v=0",
                 i, out_valid, out_instr);
      end
    end
    in_valid = 1'b1; in_instr = I_SD; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop got v=%b exp=0", out_valid);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_instr = I_LD;
    @(negedge clk);
    in_instr = I_SD;
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_imm !== 64'd0 ||
        out_fmt !== FMT_NONE || out_instr !== 32'd0 ||
        in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got v=%b imm=%h f=%0d ins=%h rdy=%b exp zeros",
               out_valid, out_imm, out_fmt, out_instr, in_ready);
    end
    reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_rel got rdy=%b v=%b exp 1 0",
               in_ready, out_valid);
    end
    apply(I_BEQ);
    checks++;
    if (out_valid !== 1'b1 || out_instr !== I_BEQ ||
        out_imm !== 64'hFFFFFFFFFFFFFFFC) begin
      errors++;
      $display("FAIL rst_mid_first got v=%b ins=%h imm=%h exp beq",
               out_valid, out_instr, out_imm);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_itype();
    test_store_branch();
    test_upper_illegal();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
